// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM encoding and the
// default pattern used by the detector benches.
package seq_gen_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP,
        DONE  = ST_DONE
    } state_t;

    // Default pattern shared with the sequence-detector benches
    localparam logic [4:0] PAT_10101 = 5'b10101;

endpackage

// File: rtl/seq_shift_ctr.sv
// Loadable MSB-first shift register with a bit counter that wraps explicitly
// at PAT_W-1. Priority: clear > load > shift.
module seq_shift_ctr #(
    parameter int unsigned PAT_W = 5
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             load,
    input  logic [PAT_W-1:0] load_val,
    input  logic             shift_en,
    output logic             msb,       // MSB the register holds after this edge
    output logic             last_bit   // current MSB is the final bit of the pattern
);

    localparam int unsigned CNT_W = $clog2(PAT_W);

    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_bit = (cnt_q == CNT_W'(PAT_W - 1));
    assign msb      = shreg_d[PAT_W-1];

    // Next-state for the shift register and bit counter
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            shreg_d = load_val;
            cnt_d   = '0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: captures a pattern and repeat count on start,
// then shifts the pattern out MSB-first for the requested repetitions.
// Optional macro SEQ_GEN_GAP_EN inserts GAP_LEN idle cycles between repetitions.
// All outputs are flops loaded from the next state, so the first bit appears the
// cycle after start is sampled.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned PAT_W   = 5,
    parameter int unsigned REP_W   = 4,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] n_reps,
    output logic             x_out,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    if (PAT_W < 2 || GAP_LEN < 1) begin : g_param_check
        $error("seq_pattern_gen: PAT_W must be >= 2 and GAP_LEN >= 1");
    end

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             sr_clear, sr_load, sr_shift, sr_msb, sr_last;
    logic [PAT_W-1:0] sr_load_val;

`ifdef SEQ_GEN_GAP_EN
    localparam int unsigned GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    seq_shift_ctr #(
        .PAT_W (PAT_W)
    ) u_shift_ctr (
        .clk      (clk),
        .nrst     (nrst),
        .clear    (sr_clear),
        .load     (sr_load),
        .load_val (sr_load_val),
        .shift_en (sr_shift),
        .msb      (sr_msb),
        .last_bit (sr_last)
    );

    // Next-state logic; abort overrides every state
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        sr_clear    = 1'b0;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_load_val = pat_q;
`ifdef SEQ_GEN_GAP_EN
        gap_d       = gap_q;
`endif
        if (abort) begin
            state_d  = IDLE;
            rep_d    = '0;
            sr_clear = 1'b1;
`ifdef SEQ_GEN_GAP_EN
            gap_d    = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (n_reps != '0) begin
                            pat_d       = pat_in;
                            rep_d       = n_reps;
                            sr_load     = 1'b1;
                            sr_load_val = pat_in;
                            state_d     = SHIFT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SHIFT: begin
                    sr_shift = 1'b1;
                    if (sr_last) begin
                        rep_d = rep_q - 1'b1;
                        if (rep_q == REP_W'(1)) begin
                            state_d  = DONE;
                            sr_clear = 1'b1;
                        end else begin
`ifdef SEQ_GEN_GAP_EN
                            state_d = GAP;
                            gap_d   = '0;
`else
                            // Back-to-back: reload from the captured copy
                            sr_load = 1'b1;
`endif
                        end
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    if (gap_q == GAP_W'(GAP_LEN - 1)) begin
                        sr_load = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            x_out   <= 1'b0;
            x_vld   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            x_out   <= (state_d == SHIFT) && sr_msb;
            x_vld   <= (state_d == SHIFT);
            busy    <= (state_d == SHIFT) || (state_d == GAP);
            done    <= (state_d == DONE);
        end
    end

`ifdef SEQ_GEN_GAP_EN
    // Inter-repetition gap counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

endmodule
